multi_debouncer: RTL and testbench

Parametrised N-channel debouncer for push-buttons and switches. Each channel has a two-flop synchroniser and a saturating stability counter. Each channel outputs a debounced level plus one-cycle rise and fall strobes, so downstream FSMs need no edge detection of their own. It sits between the board pins and the user-control logic and replaces the per-button single-channel instances.

---
 rtl/multi_debouncer_if.sv | 32 +++
 rtl/multi_debouncer.sv | 148 ++++++++++++++
 tb/tb_multi_debouncer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_debouncer_if.sv
// Pin-side bundle for multi_debouncer: raw button inputs plus the
// per-channel debounced level, edge strobes and long-press indications.
// The master side (board/test harness) drives btn; the slave side (the
// debouncer) drives all the result vectors.
interface multi_debouncer_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] btn;
    logic [NUM_CH-1:0] dbd;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] long_press;
    logic [NUM_CH-1:0] held;

    modport master (
        output btn,
        input  dbd,
        input  rise,
        input  fall,
        input  long_press,
        input  held
    );

    modport slave (
        input  btn,
        output dbd,
        output rise,
        output fall,
        output long_press,
        output held
    );
endinterface

// File: rtl/multi_debouncer.sv
// N-channel push-button / switch debouncer.
// Each channel: two-flop synchroniser, saturating stability counter,
// registered debounced level and one-cycle rise/fall strobes.
// Optional feature macro: LONG_PRESS_EN -- adds per-channel hold counters
// producing a one-cycle long_press strobe and a held level. Without it,
// long_press and held are tied low and LONG_CYCLES has no effect.
module multi_debouncer #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int INIT_LEVEL      = 0,
    parameter int LONG_CYCLES     = 4000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multi_debouncer_if.slave      bus
);

    localparam int              CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic            INIT_BIT  = 1'(INIT_LEVEL);
    localparam logic [NUM_CH-1:0] INIT_VEC = {NUM_CH{INIT_BIT}};

    logic [NUM_CH-1:0]            s0_q;
    logic [NUM_CH-1:0]            s1_q;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_d;
    logic [NUM_CH-1:0]            dbd_q;
    logic [NUM_CH-1:0]            dbd_d;
    logic [NUM_CH-1:0]            rise_q;
    logic [NUM_CH-1:0]            rise_d;
    logic [NUM_CH-1:0]            fall_q;
    logic [NUM_CH-1:0]            fall_d;

    // Two-flop synchroniser for the asynchronous button pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q <= INIT_VEC;
            s1_q <= INIT_VEC;
        end else begin
            s0_q <= bus.btn;
            s1_q <= s0_q;
        end
    end

    // Stability counter per channel: any return to the current level clears
    // it; the level only flips after DEBOUNCE_CYCLES consecutive differing
    // samples, and the strobes are produced on that same transition.
    always_comb begin
        cnt_d  = cnt_q;
        dbd_d  = dbd_q;
        rise_d = {NUM_CH{1'b0}};
        fall_d = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (s1_q[i] == dbd_q[i]) begin
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i]  = {CNT_W{1'b0}};
                dbd_d[i]  = s1_q[i];
                rise_d[i] = s1_q[i];
                fall_d[i] = ~s1_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Counter, debounced level and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {(NUM_CH*CNT_W){1'b0}};
            dbd_q  <= INIT_VEC;
            rise_q <= {NUM_CH{1'b0}};
            fall_q <= {NUM_CH{1'b0}};
        end else begin
            cnt_q  <= cnt_d;
            dbd_q  <= dbd_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bus.dbd  = dbd_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;

`ifdef LONG_PRESS_EN
    localparam int               HOLD_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    logic [NUM_CH-1:0][HOLD_W-1:0] hold_q;
    logic [NUM_CH-1:0][HOLD_W-1:0] hold_d;
    logic [NUM_CH-1:0]             held_q;
    logic [NUM_CH-1:0]             held_d;
    logic [NUM_CH-1:0]             lp_q;
    logic [NUM_CH-1:0]             lp_d;

    // Hold counter: counts only cycles after the rise edge, saturates at
    // LONG_CYCLES and fires once; the fall transition clears it together
    // with held so held drops on the same edge as the fall strobe.
    always_comb begin
        hold_d = hold_q;
        held_d = held_q;
        lp_d   = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (!dbd_d[i]) begin
                hold_d[i] = {HOLD_W{1'b0}};
                held_d[i] = 1'b0;
            end else if (dbd_q[i] && (hold_q[i] != HOLD_MAX)) begin
                hold_d[i] = hold_q[i] + HOLD_ONE;
                if (hold_q[i] == HOLD_PRE) begin
                    lp_d[i]   = 1'b1;
                    held_d[i] = 1'b1;
                end else begin
                    lp_d[i]   = 1'b0;
                end
            end else begin
                hold_d[i] = hold_q[i];
            end
        end
    end

    // Hold counter, held level and long-press strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= {(NUM_CH*HOLD_W){1'b0}};
            held_q <= {NUM_CH{1'b0}};
            lp_q   <= {NUM_CH{1'b0}};
        end else begin
            hold_q <= hold_d;
            held_q <= held_d;
            lp_q   <= lp_d;
        end
    end

    assign bus.long_press = lp_q;
    assign bus.held       = held_q;
`else
    logic unused_long_s;

    assign unused_long_s  = (LONG_CYCLES != 0);
    assign bus.long_press = {NUM_CH{1'b0}};
    assign bus.held       = {NUM_CH{1'b0}};
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer (NUM_CH=4, DEBOUNCE_CYCLES=8,
// INIT_LEVEL=0, LONG_CYCLES=32). Each scenario task checks its own
// expectations against hand-derived cycle counts.
module tb_multi_debouncer;

`ifdef LONG_PRESS_EN
    localparam bit LP_ON = 1'b1;
`else
    localparam bit LP_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    multi_debouncer_if #(.NUM_CH(4)) bus_if ();

    multi_debouncer #(
        .NUM_CH          (4),
        .DEBOUNCE_CYCLES (8),
        .INIT_LEVEL      (0),
        .LONG_CYCLES     (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.btn = 4'b0000;
        #1;
        n_checks++;
        if (bus_if.dbd !== 4'b0000 || bus_if.rise !== 4'b0000 || bus_if.fall !== 4'b0000) begin
            n_fails++;
            $display("FAIL reset_async dbd=%b rise=%b fall=%b required 0000/0000/0000",
                     bus_if.dbd, bus_if.rise, bus_if.fall);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (bus_if.dbd !== 4'b0000 || bus_if.rise !== 4'b0000 || bus_if.fall !== 4'b0000) begin
                n_fails++;
                $display("FAIL reset_hold cyc=%0d dbd=%b rise=%b fall=%b required 0000", k,
                         bus_if.dbd, bus_if.rise, bus_if.fall);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (bus_if.dbd !== 4'b0000 || bus_if.rise !== 4'b0000 || bus_if.fall !== 4'b0000) begin
                n_fails++;
                $display("FAIL reset_release cyc=%0d dbd=%b rise=%b fall=%b required 0000", k,
                         bus_if.dbd, bus_if.rise, bus_if.fall);
            end
        end
    endtask

    task automatic test_clean_step();
        bus_if.btn[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (k < 10) begin
                if (bus_if.dbd !== 4'b0000 || bus_if.rise !== 4'b0000) begin
                    n_fails++;
                    $display("FAIL step_wait edge=%0d dbd=%b rise=%b required 0000/0000", k,
                             bus_if.dbd, bus_if.rise);
                end
            end else begin
                if (bus_if.dbd !== 4'b0001 || bus_if.rise !== 4'b0001 || bus_if.fall !== 4'b0000) begin
                    n_fails++;
                    $display("FAIL step_rise dbd=%b rise=%b fall=%b required 0001/0001/0000",
                             bus_if.dbd, bus_if.rise, bus_if.fall);
                end
            end
        end
        tick();
        n_checks++;
        if (bus_if.dbd !== 4'b0001 || bus_if.rise !== 4'b0000) begin
            n_fails++;
            $display("FAIL step_pulse_width dbd=%b rise=%b required 0001/0000",
                     bus_if.dbd, bus_if.rise);
        end
    endtask

    task automatic test_bounce();
        for (int seg = 0; seg < 4; seg++) begin
            bus_if.btn[1] = (seg % 2 == 0) ? 1'b1 : 1'b0;
            for (int k = 0; k < 5; k++) begin
                tick();
                n_checks++;
                if (bus_if.dbd !== 4'b0001 || bus_if.rise !== 4'b0000 || bus_if.fall !== 4'b0000) begin
                    n_fails++;
                    $display("FAIL bounce seg=%0d cyc=%0d dbd=%b rise=%b fall=%b required 0001/0000/0000",
                             seg, k, bus_if.dbd, bus_if.rise, bus_if.fall);
                end
            end
        end
        bus_if.btn[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (k < 10) begin
                if (bus_if.dbd !== 4'b0001 || bus_if.rise !== 4'b0000) begin
                    n_fails++;
                    $display("FAIL bounce_settle edge=%0d dbd=%b rise=%b required 0001/0000", k,
                             bus_if.dbd, bus_if.rise);
                end
            end else begin
                if (bus_if.dbd !== 4'b0011 || bus_if.rise !== 4'b0010) begin
                    n_fails++;
                    $display("FAIL bounce_rise dbd=%b rise=%b required 0011/0010",
                             bus_if.dbd, bus_if.rise);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        bus_if.btn[3:2] = 2'b11;
        for (int k = 1; k <= 30; k++) begin
            if (k == 21) bus_if.btn[3:2] = 2'b00;
            tick();
            if (k == 10) begin
                n_checks++;
                if (bus_if.dbd !== 4'b1111 || bus_if.rise !== 4'b1100 || bus_if.fall !== 4'b0000) begin
                    n_fails++;
                    $display("FAIL simul_rise dbd=%b rise=%b fall=%b required 1111/1100/0000",
                             bus_if.dbd, bus_if.rise, bus_if.fall);
                end
            end else if (k == 30) begin
                n_checks++;
                if (bus_if.dbd !== 4'b0011 || bus_if.fall !== 4'b1100 || bus_if.rise !== 4'b0000) begin
                    n_fails++;
                    $display("FAIL simul_fall dbd=%b fall=%b rise=%b required 0011/1100/0000",
                             bus_if.dbd, bus_if.fall, bus_if.rise);
                end
            end else if (k == 29) begin
                n_checks++;
                if (bus_if.dbd !== 4'b1111 || bus_if.fall !== 4'b0000) begin
                    n_fails++;
                    $display("FAIL simul_before_fall dbd=%b fall=%b required 1111/0000",
                             bus_if.dbd, bus_if.fall);
                end
            end
        end
        tick();
        n_checks++;
        if (bus_if.fall !== 4'b0000 || bus_if.dbd !== 4'b0011) begin
            n_fails++;
            $display("FAIL simul_fall_width fall=%b dbd=%b required 0000/0011",
                     bus_if.fall, bus_if.dbd);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_if.dbd !== 4'b0000 || bus_if.rise !== 4'b0000 || bus_if.fall !== 4'b0000) begin
            n_fails++;
            $display("FAIL async_reset_no_edge dbd=%b rise=%b fall=%b required 0000",
                     bus_if.dbd, bus_if.rise, bus_if.fall);
        end
        bus_if.btn = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if (bus_if.dbd !== 4'b0000 || bus_if.rise !== 4'b0000 || bus_if.fall !== 4'b0000) begin
                n_fails++;
                $display("FAIL async_reset_quiet cyc=%0d dbd=%b rise=%b fall=%b required 0000", k,
                         bus_if.dbd, bus_if.rise, bus_if.fall);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        bus_if.btn[0] = 1'b1;
        // Edge 7 after the step leaves the stability counter at 5.
        for (int k = 0; k < 7; k++) tick();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (bus_if.dbd !== 4'b0000 || bus_if.rise !== 4'b0000 || bus_if.fall !== 4'b0000) begin
                n_fails++;
                $display("FAIL midcount_reset cyc=%0d dbd=%b rise=%b fall=%b required 0000", k,
                         bus_if.dbd, bus_if.rise, bus_if.fall);
            end
            tick();
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (k < 10) begin
                if (bus_if.dbd !== 4'b0000 || bus_if.rise !== 4'b0000) begin
                    n_fails++;
                    $display("FAIL midcount_wait edge=%0d dbd=%b rise=%b required 0000/0000", k,
                             bus_if.dbd, bus_if.rise);
                end
            end else begin
                if (bus_if.dbd !== 4'b0001 || bus_if.rise !== 4'b0001) begin
                    n_fails++;
                    $display("FAIL midcount_rise dbd=%b rise=%b required 0001/0001",
                             bus_if.dbd, bus_if.rise);
                end
            end
        end
    endtask

    // Entered one edge-plus-1ns after rise[0]; long_press fires 32 edges later.
    task automatic test_long_press();
        logic [3:0] exp_lp;
        logic [3:0] exp_held;
        for (int k = 1; k <= 42; k++) begin
            tick();
            exp_lp   = (LP_ON && k == 32) ? 4'b0001 : 4'b0000;
            exp_held = (LP_ON && k >= 32) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (bus_if.long_press !== exp_lp || bus_if.held !== exp_held || bus_if.dbd !== 4'b0001) begin
                n_fails++;
                $display("FAIL long_press_hold edge=%0d lp=%b held=%b dbd=%b required %b/%b/0001",
                         k, bus_if.long_press, bus_if.held, bus_if.dbd, exp_lp, exp_held);
            end
        end
        bus_if.btn[0] = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp_held = (LP_ON && k < 10) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (bus_if.held !== exp_held || bus_if.long_press !== 4'b0000 ||
                bus_if.fall !== ((k == 10) ? 4'b0001 : 4'b0000)) begin
                n_fails++;
                $display("FAIL long_press_release edge=%0d held=%b lp=%b fall=%b required held=%b lp=0000",
                         k, bus_if.held, bus_if.long_press, bus_if.fall, exp_held);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_clean_step();
        test_bounce();
        test_simultaneous();
        test_async_reset();
        test_reset_mid_count();
        test_long_press();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
